vga_sync_gen: RTL

// - 640x480@60 VGA timing generator directly upstream of the miner's display/pixel stage in super.
// - Divides clk to a pixel-enable strobe and runs horizontal/vertical counters.
// - Emits registered vga_h_sync/vga_v_sync, a display-enable and pixel coordinates.
// - super uses the coordinates to colour vga_R/G/B with hash/nonce status.

---
 rtl/vga_sync_gen.sv | 101 ++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator: pixel-enable prescaler, h/v counters and registered syncs.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_sync_gen #(
  parameter int   CLK_DIV  = 2,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pix_en,
  output logic [9:0]  h_cnt,
  output logic [9:0]  v_cnt,
  output logic        disp_en,
  output logic        line_start,
  output logic        frame_start,
`ifdef VGA_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        vga_h_sync,
  output logic        vga_v_sync
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_S_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]    H_S_HI  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]    V_S_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]    V_S_HI  = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [PW-1:0] presc;
  logic [9:0]    h_nxt, v_nxt;
  logic          frame_wrap;
  logic          h_in_sync, v_in_sync;

  // Next counter values; all registered decodes use these so they line up with h_cnt/v_cnt.
  always_comb begin
    h_nxt      = h_cnt;
    v_nxt      = v_cnt;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        if (v_cnt == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = v_cnt + 10'd1;
        end
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  assign h_in_sync = (h_nxt >= H_S_LO) && (h_nxt < H_S_HI);
  assign v_in_sync = (v_nxt >= V_S_LO) && (v_nxt < V_S_HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      pix_en      <= 1'b0;
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      disp_en     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vga_h_sync  <= ~SYNC_POL;
      vga_v_sync  <= ~SYNC_POL;
    end else begin
      presc       <= (presc == P_LAST) ? '0 : presc + PW'(1);
      pix_en      <= (presc == P_LAST);
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      disp_en     <= (h_nxt < 10'(H_ACTIVE)) && (v_nxt < 10'(V_ACTIVE));
      line_start  <= pix_en && (h_nxt == '0);
      frame_start <= frame_wrap;
      vga_h_sync  <= h_in_sync ? SYNC_POL : ~SYNC_POL;
      vga_v_sync  <= v_in_sync ? SYNC_POL : ~SYNC_POL;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             frame_cnt <= '0;
    else if (frame_wrap) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
